multichannel_oversample_filter: RTL

- Time-multiplexed, N-channel successor to the single-channel oversample filter.
- Takes tagged ADC words from the pid core, one word per cycle at most. Each channel has its own oversample ratio (2^osm), settling delay, activation and update gating.
- Emits one averaged, tagged word per completed block to the downstream clk sync / pid stage.
- Adds four things the single-channel block lacks: signed arithmetic shift, optional rounding, output saturation, and clean restart on parameter update.

---
 rtl/multichannel_oversample_filter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multichannel_oversample_filter.sv
// Time-multiplexed N-channel oversample filter: per-channel settle delay, block averaging with
// rounding, saturation and a one-cycle registered, tagged output.
//
// state    | meaning
// S_IDLE   | channel inactive, sum and count held at zero
// S_DELAY  | settling; samples for this channel are counted and discarded
// S_SAMPLE | accumulating a block of 2^osm samples
module multichannel_oversample_filter #(
  parameter int N_CHAN  = 8,
  parameter int W_CHAN  = 3,
  parameter int W_IN    = 18,
  parameter int W_OUT   = 18,
  parameter int W_OSM   = 4,
  parameter int MAX_OSM = 10,
  parameter int W_DLY   = 16,
  parameter int ROUND   = 1
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic signed [W_IN-1:0]    data_in,
  input  logic [W_CHAN-1:0]         chan_in,
  input  logic                      data_valid_in,
  input  logic [N_CHAN*W_OSM-1:0]   osm_in,
  input  logic [N_CHAN*W_DLY-1:0]   cycle_delay_in,
  input  logic [N_CHAN-1:0]         activate_in,
  input  logic [N_CHAN-1:0]         update_en_in,
  input  logic                      update_in,
  output logic signed [W_OUT-1:0]   data_out,
  output logic [W_CHAN-1:0]         chan_out,
  output logic                      data_valid_out
);

  localparam int W_SUM = W_IN + MAX_OSM + 1;
  localparam int W_CNT = (W_DLY > MAX_OSM + 1) ? W_DLY : MAX_OSM + 1;
  localparam logic [W_OSM-1:0] OSM_LIM = W_OSM'(MAX_OSM);
  localparam logic signed [W_SUM-1:0] SAT_HI = {{(W_SUM-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_SUM-1:0] SAT_LO = {{(W_SUM-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SAMPLE} state_t;

  state_t                  r_state [N_CHAN];
  logic signed [W_SUM-1:0] r_sum   [N_CHAN];
  logic [W_CNT-1:0]        r_cnt   [N_CHAN];
  logic [W_OSM-1:0]        r_osm   [N_CHAN];
  logic [W_DLY-1:0]        r_dly   [N_CHAN];

  logic [N_CHAN-1:0] w_hit, w_upd, w_dly_done, w_blk_done;
  logic [W_CNT:0]    w_cnt_inc [N_CHAN];

  always_comb begin
    for (int k = 0; k < N_CHAN; k++) begin
      w_hit[k]      = data_valid_in && ({1'b0, chan_in} == (W_CHAN+1)'(k));
      w_upd[k]      = update_in && update_en_in[k];
      w_cnt_inc[k]  = {1'b0, r_cnt[k]} + (W_CNT+1)'(1);
      w_dly_done[k] = w_cnt_inc[k] >= {{(W_CNT+1-W_DLY){1'b0}}, r_dly[k]};
      w_blk_done[k] = w_cnt_inc[k] == ((W_CNT+1)'(1) << r_osm[k]);
    end
  end

  // One shared adder/rounder/saturator serves whichever channel the current word is tagged for.
  logic                    w_chan_ok;
  logic [W_CHAN-1:0]       w_sel;
  logic signed [W_SUM-1:0] w_sum_fin, w_rnd, w_rounded, w_shifted;
  logic signed [W_OUT-1:0] w_sat;
  logic                    w_emit;

  always_comb begin
    w_chan_ok = {1'b0, chan_in} < (W_CHAN+1)'(N_CHAN);
    w_sel     = w_chan_ok ? chan_in : '0;
    w_sum_fin = r_sum[w_sel] + W_SUM'(data_in);
    w_rnd     = (ROUND != 0 && r_osm[w_sel] != '0) ?
                (W_SUM'(1) << (r_osm[w_sel] - W_OSM'(1))) : '0;
    w_rounded = w_sum_fin + w_rnd;
    w_shifted = w_rounded >>> r_osm[w_sel];
    if (w_shifted > SAT_HI)      w_sat = SAT_HI[W_OUT-1:0];
    else if (w_shifted < SAT_LO) w_sat = SAT_LO[W_OUT-1:0];
    else                         w_sat = w_shifted[W_OUT-1:0];
    w_emit = w_chan_ok && w_hit[w_sel] && activate_in[w_sel] && !w_upd[w_sel] &&
             (r_state[w_sel] == S_SAMPLE) && w_blk_done[w_sel];
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int k = 0; k < N_CHAN; k++) begin
        r_state[k] <= S_IDLE;
        r_sum[k]   <= '0;
        r_cnt[k]   <= '0;
        r_osm[k]   <= '0;
        r_dly[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < N_CHAN; k++) begin
        if (w_upd[k]) begin
          r_osm[k] <= (osm_in[k*W_OSM +: W_OSM] > OSM_LIM) ? OSM_LIM : osm_in[k*W_OSM +: W_OSM];
          r_dly[k] <= cycle_delay_in[k*W_DLY +: W_DLY];
        end
        if (!activate_in[k]) begin
          r_state[k] <= S_IDLE;
          r_sum[k]   <= '0;
          r_cnt[k]   <= '0;
        end else if (w_upd[k]) begin
          // An active channel restarts cleanly under the freshly latched parameters.
          r_sum[k]   <= '0;
          r_cnt[k]   <= '0;
          r_state[k] <= (cycle_delay_in[k*W_DLY +: W_DLY] == '0) ? S_SAMPLE : S_DELAY;
        end else if (r_state[k] == S_IDLE) begin
          r_state[k] <= (r_dly[k] == '0) ? S_SAMPLE : S_DELAY;
        end else if (w_hit[k]) begin
          if (r_state[k] == S_DELAY) begin
            if (w_dly_done[k]) begin
              r_state[k] <= S_SAMPLE;
              r_cnt[k]   <= '0;
            end else begin
              r_cnt[k] <= w_cnt_inc[k][W_CNT-1:0];
            end
          end else if (w_blk_done[k]) begin
            r_sum[k]   <= '0;
            r_cnt[k]   <= '0;
            r_state[k] <= (r_dly[k] == '0) ? S_SAMPLE : S_DELAY;
          end else begin
            r_sum[k] <= w_sum_fin;
            r_cnt[k] <= w_cnt_inc[k][W_CNT-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      data_out       <= '0;
      chan_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= w_emit;
      if (w_emit) begin
        data_out <= w_sat;
        chan_out <= chan_in;
      end
    end
  end

endmodule
